// File: rtl/mux_pkg.sv
// Shared constants for the N-channel registered multiplexer and its arbiter.
package mux_pkg;

    // Selection mode encoding for the modo input
    localparam logic MODO_FIXO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

endpackage : mux_pkg

// File: rtl/arbitro_rr.sv
// Round-robin arbiter: rotating-priority search starting at ptr, one-hot grant.
// ptr moves to one past the granted channel whenever avanca is asserted.
module arbitro_rr #(
    parameter int N = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N-1:0]                 req,
    input  logic                         avanca,
    output logic [N-1:0]                 grant,
    output logic [$clog2(N)-1:0]         grant_idx
);

    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] cand;
    logic             found;

    // Search req starting at ptr, wrapping past N-1 back to 0; first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_reg} + (SEL_W+1)'(i);
            if (sum >= (SEL_W+1)'(N)) begin
                sum = sum - (SEL_W+1)'(N);
            end
            cand = sum[SEL_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next pointer: one past the granted channel, wrapping (N need not be a power of two)
    always_comb begin
        if ({1'b0, grant_idx} == (SEL_W+1)'(N - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + SEL_W'(1);
        end
    end

    // Pointer register; only advances on a round-robin transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (avanca) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule : arbitro_rr

// File: rtl/mux_arbitro_n.sv
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshake.
// Channel chosen by controle (fixed mode) or by a round-robin arbiter.
module mux_arbitro_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 modo,
    input  logic [SEL_W-1:0]     controle,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     saida,
    output logic                 saida_valid,
    input  logic                 saida_ready,
    output logic [SEL_W-1:0]     canal
);

    logic [WIDTH-1:0] ch_data [N];
    logic [N-1:0]     rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] sel;
    logic             load_en;
    logic             ctrl_ok;
    logic             transfer;
    logic             avanca;

    // Unflatten the input bus into one word per channel
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign load_en  = !saida_valid || saida_ready;
    // controle may exceed N-1 when N is not a power of two
    assign ctrl_ok  = ({1'b0, controle} < (SEL_W+1)'(N));
    assign transfer = |(in_valid & in_ready);
    assign avanca   = transfer && (modo == MODO_RR);

    arbitro_rr #(
        .N(N)
    ) u_arbitro (
        .clock     (clock),
        .reset     (reset),
        .req       (in_valid),
        .avanca    (avanca),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Grant selection: fixed index readiness ignores in_valid, round-robin follows the arbiter
    always_comb begin
        in_ready = '0;
        sel      = controle;
        if (modo == MODO_RR) begin
            sel = rr_idx;
            if (load_en) begin
                in_ready = rr_grant;
            end
        end else if (ctrl_ok && load_en) begin
            in_ready = N'(1) << controle;
        end
    end

    // Output register: load on transfer, drop valid when consumed, hold while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida       <= '0;
            saida_valid <= 1'b0;
            canal       <= '0;
        end else if (transfer) begin
            saida       <= ch_data[sel];
            canal       <= sel;
            saida_valid <= 1'b1;
        end else if (saida_ready) begin
            saida_valid <= 1'b0;
        end
    end

endmodule : mux_arbitro_n

// File: tb/tb_mux_arbitro_n.sv
// Bench for mux_arbitro_n: directed scenarios plus randomized traffic checked
// against a transaction-level model (N=4), and a directed N=3 instance.
module tb_mux_arbitro_n;

    logic        clk = 1'b0;
    logic        reset;

    // N=4 instance
    logic        modo;
    logic [1:0]  controle;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [7:0]  saida;
    logic        saida_valid;
    logic        saida_ready;
    logic [1:0]  canal;

    // N=3 instance
    logic        m3_modo;
    logic [1:0]  m3_controle;
    logic [2:0]  m3_in_valid;
    logic [23:0] m3_in_data;
    logic [2:0]  m3_in_ready;
    logic [7:0]  m3_saida;
    logic        m3_saida_valid;
    logic        m3_saida_ready;
    logic [1:0]  m3_canal;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model state
    logic [7:0] m_saida;
    logic       m_valid;
    int         m_canal;
    int         m_ptr;

    always #5 clk = ~clk;

    mux_arbitro_n #(.WIDTH(8), .N(4)) dut (
        .clock       (clk),
        .reset       (reset),
        .modo        (modo),
        .controle    (controle),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .saida       (saida),
        .saida_valid (saida_valid),
        .saida_ready (saida_ready),
        .canal       (canal)
    );

    mux_arbitro_n #(.WIDTH(8), .N(3)) dut3 (
        .clock       (clk),
        .reset       (reset),
        .modo        (m3_modo),
        .controle    (m3_controle),
        .in_valid    (m3_in_valid),
        .in_data     (m3_in_data),
        .in_ready    (m3_in_ready),
        .saida       (m3_saida),
        .saida_valid (m3_saida_valid),
        .saida_ready (m3_saida_ready),
        .canal       (m3_canal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected in_ready from the handshake rules
    function automatic logic [3:0] model_ready(input logic md, input logic [1:0] ct,
                                               input logic [3:0] vl, input int ptr,
                                               input logic sv, input logic sr);
        logic [3:0] one;
        one = 4'b0001;
        if (sv && !sr) return 4'b0000;
        if (!md) return one << ct;
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (ptr + i) % 4;
            if (vl[c]) return one << c;
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_saida = 8'h00;
        m_valid = 1'b0;
        m_canal = 0;
        m_ptr   = 0;
    endtask

    // One cycle: drive, check in_ready, clock, update model, check outputs
    task automatic step(input logic md, input logic [1:0] ct, input logic [3:0] vl,
                        input logic [31:0] dt, input logic sr);
        logic [3:0] er;
        int k;
        modo = md; controle = ct; in_valid = vl; in_data = dt; saida_ready = sr;
        #1;
        er = model_ready(md, ct, vl, m_ptr, m_valid, sr);
        check("in_ready", {28'd0, in_ready}, {28'd0, er});
        k = -1;
        for (int i = 0; i < 4; i++) if (vl[i] && er[i]) k = i;
        @(posedge clk);
        if (k >= 0) begin
            m_saida = dt[k*8 +: 8];
            m_canal = k;
            m_valid = 1'b1;
            if (md) m_ptr = (k + 1) % 4;
        end else if (sr) begin
            m_valid = 1'b0;
        end
        #1;
        check("saida", {24'd0, saida}, {24'd0, m_saida});
        check("saida_valid", {31'd0, saida_valid}, {31'd0, m_valid});
        check("canal", {30'd0, canal}, m_canal);
        $display("txn modo=%0d ctl=%0d vld=%b rdy=%b sr=%0d -> saida=%02h v=%0d canal=%0d",
                 md, ct, vl, in_ready, sr, saida, saida_valid, canal);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_saida", {24'd0, saida}, 32'd0);
        check("rst_valid", {31'd0, saida_valid}, 32'd0);
        check("rst_canal", {30'd0, canal}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        modo = 1'b0; controle = 2'd0; in_valid = 4'd0; in_data = 32'd0; saida_ready = 1'b1;
        m3_modo = 1'b0; m3_controle = 2'd0; m3_in_valid = 3'd0; m3_in_data = 24'd0;
        m3_saida_ready = 1'b1;
        model_reset();
        #2;
        // Reset with arbitrary inputs on the N=4 instance
        modo = 1'b1; in_valid = 4'b1111; in_data = 32'hDEADBEEF; saida_ready = 1'b0;
        do_reset();
        modo = 1'b0; in_valid = 4'd0; saida_ready = 1'b1;

        // N=3: load ch1, stall, then select out-of-range controle
        m3_controle = 2'd1; m3_in_valid = 3'b010; m3_in_data = 24'h005A00; m3_saida_ready = 1'b0;
        #1;
        check("n3_ready_load", {29'd0, m3_in_ready}, 32'b010);
        @(posedge clk); #1;
        check("n3_saida", {24'd0, m3_saida}, 32'h5A);
        check("n3_valid_held", {31'd0, m3_saida_valid}, 32'd1);
        m3_controle = 2'd3;
        #1;
        check("n3_ready_oob", {29'd0, m3_in_ready}, 32'd0);
        m3_saida_ready = 1'b1;
        #1;
        check("n3_ready_oob_sr", {29'd0, m3_in_ready}, 32'd0);
        @(posedge clk); #1;
        check("n3_valid_fall", {31'd0, m3_saida_valid}, 32'd0);
        check("n3_saida_kept", {24'd0, m3_saida}, 32'h5A);
        m3_in_valid = 3'd0;

        // Fixed mode basic load
        do_reset();
        step(1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1);
        check("fixed_a5", {24'd0, saida}, 32'hA5);
        check("fixed_canal", {30'd0, canal}, 32'd2);

        // Back-pressure with no bubble on release
        step(1'b0, 2'd2, 4'b0100, 32'h003C0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd2, 4'b0100, 32'h00FF0000, 1'b0);
            check("bp_hold", {24'd0, saida}, 32'h3C);
        end
        step(1'b0, 2'd2, 4'b0100, 32'h00FF0000, 1'b1);
        check("bp_release", {24'd0, saida}, 32'hFF);
        check("bp_nobubble", {31'd0, saida_valid}, 32'd1);

        // Round-robin fairness from ptr=0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'd0, 4'b1111, 32'h44332211, 1'b1);
            check("rr_fair", {30'd0, canal}, i % 4);
        end

        // Sparse round-robin with wrap: ptr to 1 first
        do_reset();
        step(1'b1, 2'd0, 4'b0001, 32'h00000011, 1'b1);
        step(1'b1, 2'd0, 4'b1001, 32'h44000011, 1'b1);
        check("rr_sparse0", {30'd0, canal}, 32'd3);
        step(1'b1, 2'd0, 4'b1001, 32'h44000011, 1'b1);
        check("rr_sparse1", {30'd0, canal}, 32'd0);
        step(1'b1, 2'd0, 4'b1001, 32'h44000011, 1'b1);
        check("rr_sparse2", {30'd0, canal}, 32'd3);

        // Mode switch mid-stall, then reset mid-stall
        step(1'b0, 2'd1, 4'b0010, 32'h00007700, 1'b1);
        step(1'b1, 2'd1, 4'b1111, 32'h11223344, 1'b0);
        check("sw_saida", {24'd0, saida}, 32'h77);
        check("sw_canal", {30'd0, canal}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_stall_valid", {31'd0, saida_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1, 2'd0, 4'b1111, 32'h44332211, 1'b1);
        check("rst_ptr0", {30'd0, canal}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                 $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux_arbitro_n

// File: doc/mux_arbitro_n.md
# mux_arbitro_n

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshake and a selectable round-robin arbitration mode. It generalises the datapath 2:1 8-bit selector: the output is registered, back-pressure is honoured, and channels can be chosen either by an explicit `controle` index or by fair rotation among requesting channels. It sits between multiple producers (e.g. writeback sources or memory-response paths) and a single consumer.

## Interface
Parameters:
- `WIDTH`, 8: data width per channel.
- `N`, 4: channel count, at least 2; need not be a power of two.
- `SEL_W`, `$clog2(N)`: derived index width; not overridden.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `modo`  in  1  0 = fixed selection by `controle`; 1 = round-robin.
- `controle`  in  SEL_W  channel index used when `modo`=0.
- `in_valid`  in  N  per-channel data valid.
- `in_data`  in  N*WIDTH  flattened inputs; channel i is bits [i*WIDTH +: WIDTH].
- `in_ready`  out  N  per-channel accept; at most one bit high.
- `saida`  out  WIDTH  registered output data.
- `saida_valid`  out  1  `saida` holds an untaken word.
- `saida_ready`  in  1  consumer accepts `saida` this cycle.
- `canal`  out  SEL_W  index of the channel that supplied `saida`.

## Operation
- Load enable: `load_en = !saida_valid || saida_ready`.
- Fixed mode (`modo`=0):
  - If `controle` < N, then `in_ready[controle] = load_en`, regardless of `in_valid`.
  - If `controle` ≥ N, then `in_ready` is all 0 and nothing loads.
  - The round-robin pointer is not changed.
- Round-robin mode (`modo`=1):
  - The grant goes to the first channel with `in_valid`=1, searching `ptr`, `ptr`+1, …, N-1, 0, …, `ptr`-1.
  - `in_ready[grant] = load_en`. All other `in_ready` bits are 0. If no channel is valid, `in_ready` is all 0.
- Transfer on channel k means `in_valid[k] && in_ready[k]`. At the next edge:
  - `saida` ← channel k data.
  - `canal` ← k.
  - `saida_valid` ← 1.
  - In round-robin mode only, `ptr` ← k+1, wrapping from N-1 to 0.
- No transfer while `saida_ready`=1: `saida_valid` ← 0. `saida` and `canal` keep their last values.
- Stall (`saida_valid`=1, `saida_ready`=0): `saida`, `canal` and `saida_valid` are held bit-stable. `in_ready` is all 0.
- Simultaneous consume and load: the new word replaces the old one in the same edge, with no bubble.
- `modo` and `controle` are sampled combinationally each cycle. A change takes effect in the same cycle and does not affect a word already held in `saida`.

## Timing
- Reset (asynchronous assert, synchronous release): `saida`=0, `saida_valid`=0, `canal`=0, `ptr`=0. `in_ready` is then driven purely from the combinational rules above.
- Reset asserted mid-stall: the held word is discarded immediately.
- Latency: 1 cycle from transfer to `saida_valid`.
- Throughput: 1 word/cycle when `saida_ready` is held at 1.
- Combinational paths: `saida_ready`, `in_valid`, `modo`, `controle` → `in_ready`. No path from `in_data` to any output other than through the register.
- Round-robin fairness: with all N channels continuously valid, each channel is served exactly once in every N consecutive transfers.

## Structure
- Shared package `mux_pkg`: constants `MODO_FIXO`=1'b0 and `MODO_RR`=1'b1.
- Sub-module `arbitro_rr`:
  - Parameter: `N`.
  - Inputs: `clock`, `reset`, `req[N-1:0]`, `avanca`.
  - Output: one-hot `grant`.
  - Contains the `ptr` register and the rotating priority search.
  - `avanca` is asserted on a round-robin-mode transfer.
- The top level contains the fixed/round-robin grant mux, the data mux, the output register and the handshake logic.

## Test plan
- **Reset:** assert `reset` with arbitrary inputs → `saida`=0, `saida_valid`=0, `canal`=0. Release, then fixed mode, `controle`=2, `in_data` ch2=8'hA5, `in_valid`=4'b0100, `saida_ready`=1 → `in_ready`=4'b0100; next cycle `saida`=8'hA5, `canal`=2.
- **Back-pressure:** load 8'h3C, hold `saida_ready`=0 for 3 cycles while ch2 changes to 8'hFF → `saida` stays 8'h3C and `in_ready`=0. Raise `saida_ready` → 8'hFF loads with no bubble cycle.
- **Round-robin fairness:** `modo`=1, N=4, all valid, `saida_ready`=1 for 8 cycles → `canal` sequence is 0,1,2,3,0,1,2,3.
- **Sparse round-robin and wrap:** valid only ch3 and ch0, with `ptr`=1 → grants ch3, then ch0, then ch3.
- **Non-power-of-two N:** N=3, fixed mode, `controle`=3 → `in_ready`=0 and `saida_valid` falls after the pending word is consumed.
- **Mode switch and reset during stall:** stalled word with `canal`=1; switch `modo` mid-stall → `saida` is unchanged. Then assert `reset` mid-stall → `saida_valid`=0 immediately and `ptr`=0.
